// File: rtl/text_console_pkg.sv
// rtl/text_console_pkg.sv - shared constants, control codes and state type for the text console writer
// Contents: screen geometry defaults, blank fill code, control code values,
//           FSM state enum and a printable-byte predicate.
package text_console_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 25;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_TAB = 8'h09;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_ALL  = 2'd1,
    CLEAR_LINE = 2'd2
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// rtl/text_cursor.sv - cursor position register with per-code next-cursor decode
// Ports: clk, rst (async, active-high); step applies the decode of code to the
//        cursor; home forces 0,0; col/row are the registered cursor;
//        line_advance flags codes that move to a new (cleared) line;
//        row_base = row*COLS and cur_addr = row*COLS+col in text RAM space.
module text_cursor #(
  parameter int COLS   = text_console_pkg::DEF_COLS,
  parameter int ROWS   = text_console_pkg::DEF_ROWS,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              home,
  input  logic [7:0]        code,
  output logic [6:0]        col,
  output logic [4:0]        row,
  output logic              line_advance,
  output logic [ADDR_W-1:0] row_base,
  output logic [ADDR_W-1:0] cur_addr
);
  import text_console_pkg::*;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic [6:0] col_q, col_d, new_col;
  logic [4:0] row_q, row_d;
  logic [7:0] tab_col;

  // Decode is evaluated every cycle; it only takes effect when step is high.
  always_comb begin
    new_col      = col_q;
    line_advance = 1'b0;
    // Next multiple of 8; 8 bits wide so the 80 overflow case is visible.
    tab_col      = {1'b0, col_q | 7'd7} + 8'd1;
    if (is_printable(code)) begin
      if (col_q == LAST_COL) begin
        new_col      = 7'd0;
        line_advance = 1'b1;
      end else begin
        new_col = col_q + 7'd1;
      end
    end else begin
      case (code)
        CC_CR:  new_col = 7'd0;
        CC_LF:  line_advance = 1'b1;
        CC_BS:  if (col_q != 7'd0) new_col = col_q - 7'd1;
        CC_TAB: begin
          if (tab_col >= 8'(COLS)) begin
            new_col      = 7'd0;
            line_advance = 1'b1;
          end else begin
            new_col = tab_col[6:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (home) begin
      col_d = 7'd0;
      row_d = 5'd0;
    end else if (step) begin
      col_d = new_col;
      if (line_advance) row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= 7'd0;
      row_q <= 5'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign row_base = ADDR_W'(row_q) * ADDR_W'(COLS);
  assign cur_addr = row_base + ADDR_W'(col_q);
  assign col      = col_q;
  assign row      = row_q;

endmodule

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte stream to text RAM writer with cursor, control codes and clears
// Ports: clk, reset (async, active-high); char_data/char_valid/char_ready byte
//        handshake; write_address/write_data/write_en text RAM write port;
//        cursor_col/cursor_row current cursor; busy high while clearing.
module text_console_writer #(
  parameter int         COLS       = text_console_pkg::DEF_COLS,
  parameter int         ROWS       = text_console_pkg::DEF_ROWS,
  parameter int         ADDR_W     = 11,
  parameter logic [7:0] BLANK_CHAR = text_console_pkg::BLANK_CHAR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char_data,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        write_data,
  output logic              write_en,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);
  import text_console_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ALL  = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(COLS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              accept, home, line_advance;
  logic [ADDR_W-1:0] row_base, cur_addr;

  // ready_q is only ever high in IDLE, so this is the full handshake.
  assign accept = char_valid && ready_q;

  text_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
    .clk          (clk),
    .rst          (reset),
    .step         (accept),
    .home         (home),
    .code         (char_data),
    .col          (cursor_col),
    .row          (cursor_row),
    .line_advance (line_advance),
    .row_base     (row_base),
    .cur_addr     (cur_addr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    home    = 1'b0;
    case (state_q)
      CLEAR_ALL: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = BLANK_CHAR;
        if (cnt_q == LAST_ALL) begin
          state_d = IDLE;
          cnt_d   = '0;
          home    = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      CLEAR_LINE: begin
        // The cursor row already points at the new line here.
        we_d   = 1'b1;
        addr_d = row_base + cnt_q;
        data_d = BLANK_CHAR;
        if (cnt_q == LAST_LINE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (accept) begin
          if (is_printable(char_data)) begin
            we_d   = 1'b1;
            addr_d = cur_addr;
            data_d = char_data;
          end else if (char_data == CC_BS && cursor_col != 7'd0) begin
            we_d   = 1'b1;
            addr_d = cur_addr - ADDR_W'(1);
            data_d = BLANK_CHAR;
          end
          if (char_data == CC_FF) begin
            state_d = CLEAR_ALL;
            cnt_d   = '0;
          end else if (line_advance) begin
            state_d = CLEAR_LINE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR_ALL;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign char_ready    = ready_q;
  assign busy          = busy_q;
  assign write_en      = we_q;
  assign write_address = addr_q;
  assign write_data    = data_q;

endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - self-checking bench for text_console_writer
module tb_text_console_writer;
  localparam int COLS   = 80;
  localparam int ROWS   = 25;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        char_data = 8'h00;
  logic              char_valid = 1'b0;
  logic              char_ready, write_en, busy;
  logic [ADDR_W-1:0] write_address;
  logic [7:0]        write_data;
  logic [6:0]        cursor_col;
  logic [4:0]        cursor_row;

  text_console_writer dut (
    .clk           (clk),
    .reset         (reset),
    .char_data     (char_data),
    .char_valid    (char_valid),
    .char_ready    (char_ready),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .cursor_col    (cursor_col),
    .cursor_row    (cursor_row),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes {addr,data} with the cycle they were seen in; expected writes from the model.
  logic [18:0] wq[$];
  int          wcyc[$];
  logic [18:0] exp_q[$];
  int          mcol = 0;
  int          mrow = 0;

  always @(negedge clk) begin
    if (write_en) begin
      wq.push_back({write_address, write_data});
      wcyc.push_back(cyc);
    end
  end

  // ---------------- reference model: screen/cursor rules ----------------
  task automatic model_push(input int addr, input logic [7:0] d);
    exp_q.push_back({11'(addr), d});
  endtask

  task automatic model_new_line();
    mrow = (mrow + 1) % ROWS;
    for (int c = 0; c < COLS; c++) model_push(mrow * COLS + c, 8'h20);
  endtask

  task automatic model_full_clear();
    for (int a = 0; a < COLS * ROWS; a++) model_push(a, 8'h20);
    mcol = 0;
    mrow = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      model_push(mrow * COLS + mcol, b);
      if (mcol == COLS - 1) begin
        mcol = 0;
        model_new_line();
      end else begin
        mcol++;
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      model_new_line();
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        model_push(mrow * COLS + mcol, 8'h20);
      end
    end else if (b == 8'h09) begin
      mcol = (mcol | 7) + 1;
      if (mcol >= COLS) begin
        mcol = 0;
        model_new_line();
      end
    end else if (b == 8'h0C) begin
      model_full_clear();
    end
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(32, 126));
  endfunction

  function automatic int first_diff();
    int n;
    n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (wq[i] !== exp_q[i]) return i;
    if (wq.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [18:0] at_q(input logic [18:0] q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : '1;
  endfunction

  task automatic clear_logs();
    wq.delete();
    wcyc.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; drives the bytes in order, holding each until accepted.
  task automatic send_stream(input logic [7:0] bytes[$]);
    int i = 0;
    int guard = 0;
    while (i < bytes.size() && guard < 20000) begin
      char_valid = 1'b1;
      char_data  = bytes[i];
      if (char_ready) begin
        model_byte(bytes[i]);
        i++;
      end
      @(negedge clk);
      guard++;
    end
    char_valid = 1'b0;
    vectors++;
    if (i != bytes.size()) begin
      miscompares++;
      $display("FAIL send_timeout: accepted %0d bytes, required %0d", i, bytes.size());
    end
  endtask

  // Counts negedges with char_ready low, then settles so the monitor has every write.
  task automatic wait_idle(output int low);
    low = 0;
    while (!char_ready && low < 5000) begin
      @(negedge clk);
      low++;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int low, idx;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({write_en, char_ready, busy} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_flags: we/ready/busy got %b required 001", {write_en, char_ready, busy});
    end
    vectors++;
    if (write_address !== '0 || write_data !== 8'h00 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_values: addr %0d data %h col %0d row %0d required all 0",
               write_address, write_data, cursor_col, cursor_row);
    end
    clear_logs();
    model_full_clear();
    reset = 1'b0;
    @(negedge clk);
    wait_idle(low);
    idx = first_diff();
    vectors++;
    if (idx >= 0) begin
      miscompares++;
      $display("FAIL reset_clear: write %0d got %h required %h (count %0d required %0d)",
               idx, at_q(wq, idx), at_q(exp_q, idx), wq.size(), exp_q.size());
    end
    vectors++;
    if (wcyc.size() != COLS * ROWS || wcyc[wcyc.size()-1] - wcyc[0] != COLS * ROWS - 1) begin
      miscompares++;
      $display("FAIL reset_clear_span: %0d writes not on consecutive cycles, required %0d", wcyc.size(), COLS * ROWS);
    end
    vectors++;
    if ({char_ready, busy} !== 2'b10 || cursor_col !== 7'(mcol) || cursor_row !== 5'(mrow)) begin
      miscompares++;
      $display("FAIL reset_idle: ready %b busy %b col %0d row %0d required ready 1 busy 0 col %0d row %0d",
               char_ready, busy, cursor_col, cursor_row, mcol, mrow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[$];
    int low, idx;
    clear_logs();
    s = '{8'h48, 8'h69};
    send_stream(s);
    wait_idle(low);
    idx = first_diff();
    vectors++;
    if (idx >= 0) begin
      miscompares++;
      $display("FAIL b2b_writes: write %0d got %h required %h", idx, at_q(wq, idx), at_q(exp_q, idx));
    end
    vectors++;
    if (wcyc.size() != 2 || wcyc[1] != wcyc[0] + 1) begin
      miscompares++;
      $display("FAIL b2b_timing: %0d writes, required 2 on consecutive cycles", wcyc.size());
    end
    vectors++;
    if (cursor_col !== 7'(mcol)) begin
      miscompares++;
      $display("FAIL b2b_cursor: col %0d required %0d", cursor_col, mcol);
    end
  endtask

  task automatic test_corner_wrap();
    logic [7:0] s[$];
    int low, idx;
    clear_logs();
    for (int i = 0; i < ROWS - 1; i++) s.push_back(8'h0A);
    s.push_back(8'h0D);
    for (int i = 0; i < 9; i++) s.push_back(8'h09);
    for (int i = 0; i < 7; i++) s.push_back(rand_print());
    send_stream(s);
    wait_idle(low);
    idx = first_diff();
    vectors++;
    if (idx >= 0 || cursor_col !== 7'(mcol) || cursor_row !== 5'(mrow)) begin
      miscompares++;
      $display("FAIL corner_setup: write %0d got %h required %h, cursor %0d,%0d required %0d,%0d",
               idx, at_q(wq, idx), at_q(exp_q, idx), cursor_col, cursor_row, mcol, mrow);
    end
    clear_logs();
    s = '{8'h41};
    send_stream(s);
    wait_idle(low);
    vectors++;
    if (wq.size() < 1 || wq[0] !== {11'd1999, 8'h41}) begin
      miscompares++;
      $display("FAIL corner_char: got %h required %h", at_q(wq, 0), {11'd1999, 8'h41});
    end
    idx = first_diff();
    vectors++;
    if (idx >= 0) begin
      miscompares++;
      $display("FAIL corner_clear: write %0d got %h required %h (count %0d required %0d)",
               idx, at_q(wq, idx), at_q(exp_q, idx), wq.size(), exp_q.size());
    end
    vectors++;
    if (low != COLS) begin
      miscompares++;
      $display("FAIL corner_ready_low: %0d cycles, required %0d", low, COLS);
    end
    vectors++;
    if (cursor_col !== 7'(mcol) || cursor_row !== 5'(mrow)) begin
      miscompares++;
      $display("FAIL corner_cursor: %0d,%0d required %0d,%0d", cursor_col, cursor_row, mcol, mrow);
    end
  endtask

  task automatic test_backspace();
    logic [7:0] s[$];
    int low, idx;
    clear_logs();
    s.push_back(8'h0D);
    for (int i = 0; i < 5; i++) s.push_back(rand_print());
    s.push_back(8'h08);
    send_stream(s);
    wait_idle(low);
    idx = first_diff();
    vectors++;
    if (idx >= 0 || wq.size() < 1 || wq[wq.size()-1] !== {11'(mrow * COLS + 4), 8'h20}) begin
      miscompares++;
      $display("FAIL bs_write: write %0d got %h required %h, last %h required %h", idx,
               at_q(wq, idx), at_q(exp_q, idx), at_q(wq, wq.size() - 1), {11'(mrow * COLS + 4), 8'h20});
    end
    vectors++;
    if (cursor_col !== 7'(mcol)) begin
      miscompares++;
      $display("FAIL bs_cursor: col %0d required %0d", cursor_col, mcol);
    end
    clear_logs();
    s = '{8'h0D, 8'h08};
    send_stream(s);
    wait_idle(low);
    vectors++;
    if (wq.size() != 0 || cursor_col !== 7'd0) begin
      miscompares++;
      $display("FAIL bs_col0: %0d writes col %0d, required 0 writes col 0", wq.size(), cursor_col);
    end
  endtask

  task automatic test_tab_cr();
    logic [7:0] s[$];
    int low, idx;
    clear_logs();
    s.push_back(8'h0D);
    for (int i = 0; i < 3; i++) s.push_back(rand_print());
    s.push_back(8'h09);
    send_stream(s);
    wait_idle(low);
    idx = first_diff();
    vectors++;
    if (idx >= 0 || cursor_col !== 7'(mcol)) begin
      miscompares++;
      $display("FAIL tab_small: write %0d got %h required %h, col %0d required %0d",
               idx, at_q(wq, idx), at_q(exp_q, idx), cursor_col, mcol);
    end
    clear_logs();
    s.delete();
    s.push_back(8'h0D);
    for (int i = 0; i < 9; i++) s.push_back(8'h09);
    for (int i = 0; i < 3; i++) s.push_back(rand_print());
    s.push_back(8'h09);
    send_stream(s);
    wait_idle(low);
    idx = first_diff();
    vectors++;
    if (idx >= 0 || cursor_col !== 7'(mcol) || cursor_row !== 5'(mrow)) begin
      miscompares++;
      $display("FAIL tab_wrap: write %0d got %h required %h, cursor %0d,%0d required %0d,%0d",
               idx, at_q(wq, idx), at_q(exp_q, idx), cursor_col, cursor_row, mcol, mrow);
    end
    clear_logs();
    s = '{8'h61, 8'h62, 8'h0D};
    send_stream(s);
    wait_idle(low);
    vectors++;
    if (cursor_col !== 7'(mcol) || first_diff() >= 0) begin
      miscompares++;
      $display("FAIL cr: col %0d required %0d, writes %0d required %0d", cursor_col, mcol, wq.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] s[$];
    int low, idx, r, b;
    clear_logs();
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = rand_print();
      else if (r < 68) b = 8'h0D;
      else if (r < 74) b = 8'h0A;
      else if (r < 82) b = 8'h08;
      else if (r < 90) b = 8'h09;
      else if (r < 98) begin
        b = $urandom_range(0, 255);
        while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h09 || b == 8'h0A ||
               b == 8'h0C || b == 8'h0D)
          b = $urandom_range(0, 255);
      end else b = 8'h0C;
      s.push_back(8'(b));
    end
    send_stream(s);
    wait_idle(low);
    idx = first_diff();
    vectors++;
    if (idx >= 0) begin
      miscompares++;
      $display("FAIL random_writes: write %0d got %h required %h (count %0d required %0d)",
               idx, at_q(wq, idx), at_q(exp_q, idx), wq.size(), exp_q.size());
    end
    vectors++;
    if (cursor_col !== 7'(mcol) || cursor_row !== 5'(mrow)) begin
      miscompares++;
      $display("FAIL random_cursor: %0d,%0d required %0d,%0d", cursor_col, cursor_row, mcol, mrow);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] s[$];
    int low, idx, seen, guard;
    s = '{8'h0A, 8'h0D, 8'h09, 8'h0C};
    send_stream(s);
    seen = 0;
    guard = 0;
    while (seen < 500 && guard < 3000) begin
      if (write_en) seen++;
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (write_en !== 1'b0 || busy !== 1'b1 || char_ready !== 1'b0 || write_address !== '0) begin
      miscompares++;
      $display("FAIL midreset_async: we %b busy %b ready %b addr %0d required 0 1 0 0 (after %0d writes)",
               write_en, busy, char_ready, write_address, seen);
    end
    vectors++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      miscompares++;
      $display("FAIL midreset_cursor: %0d,%0d required 0,0", cursor_col, cursor_row);
    end
    repeat (2) @(negedge clk);
    clear_logs();
    model_full_clear();
    reset = 1'b0;
    @(negedge clk);
    wait_idle(low);
    idx = first_diff();
    vectors++;
    if (idx >= 0) begin
      miscompares++;
      $display("FAIL midreset_restart: write %0d got %h required %h (count %0d required %0d)",
               idx, at_q(wq, idx), at_q(exp_q, idx), wq.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_corner_wrap();
    test_backspace();
    test_tab_cr();
    test_random();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
